// File: rtl/ascon_ctrl_fsm_if.sv
// rtl/ascon_ctrl_fsm_if.sv - control, handshake and datapath-enable bundle of the Ascon sequencer
interface ascon_ctrl_fsm_if #(
  parameter int BLK_W = 8
);
  logic             i_sys_enable;
  logic             i_start;
  logic             i_decrypt;
  logic             i_ad_present;
  logic             i_data_valid;
  logic             i_last_block;
  logic             o_ready;
  logic             o_busy;
  logic [3:0]       o_round;
  logic [BLK_W-1:0] o_block_count;
  logic             o_mux_select;
  logic             o_state_en;
  logic             o_xor_data_begin;
  logic             o_xor_key_begin;
  logic             o_xor_key_end;
  logic             o_xor_lsb_end;
  logic             o_replace_data;
  logic             o_valid_out;
  logic             o_tag_en;
  logic             o_done;

  modport slave (
    input  i_sys_enable, i_start, i_decrypt, i_ad_present, i_data_valid, i_last_block,
    output o_ready, o_busy, o_round, o_block_count, o_mux_select, o_state_en,
           o_xor_data_begin, o_xor_key_begin, o_xor_key_end, o_xor_lsb_end,
           o_replace_data, o_valid_out, o_tag_en, o_done
  );

  modport master (
    output i_sys_enable, i_start, i_decrypt, i_ad_present, i_data_valid, i_last_block,
    input  o_ready, o_busy, o_round, o_block_count, o_mux_select, o_state_en,
           o_xor_data_begin, o_xor_key_begin, o_xor_key_end, o_xor_lsb_end,
           o_replace_data, o_valid_out, o_tag_en, o_done
  );
endinterface

// File: rtl/ascon_ctrl_fsm.sv
// rtl/ascon_ctrl_fsm.sv - Ascon AEAD control sequencer: p^a/p^b round stepping and datapath enables
module ascon_ctrl_fsm #(
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 6,
  parameter int BLK_W    = 8
) (
  input  logic            clock,
  input  logic            reset_n,
  ascon_ctrl_fsm_if.slave bus
);

  generate
    if (ROUNDS_B < 1 || ROUNDS_B > ROUNDS_A || ROUNDS_A > 12) begin : g_bad_rounds
      $error("ascon_ctrl_fsm: rounds must satisfy 1 <= ROUNDS_B <= ROUNDS_A <= 12");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INIT_RUN  = 3'd1,
    S_AD_WAIT   = 3'd2,
    S_AD_RUN    = 3'd3,
    S_DATA_WAIT = 3'd4,
    S_DATA_RUN  = 3'd5,
    S_FINAL_RUN = 3'd6,
    S_DONE      = 3'd7
  } state_t;

  localparam logic [3:0]       LEN_A   = 4'(ROUNDS_A);
  localparam logic [3:0]       LEN_B   = 4'(ROUNDS_B);
  localparam logic [3:0]       BASE_A  = 4'(12 - ROUNDS_A);
  localparam logic [3:0]       BASE_B  = 4'(12 - ROUNDS_B);
  localparam logic [BLK_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_round_cnt;
  logic [BLK_W-1:0] r_block_count;
  logic             r_decrypt;
  logic             r_ad_present;
  logic             r_last_ad;

  logic             w_run_a;
  logic             w_run_b;
  logic             w_running;
  logic             w_first;
  logic             w_last;
  logic             w_ready;
  logic             w_xfer;
  logic [3:0]       w_len;
  logic [3:0]       w_base;

  always_comb begin
    w_run_a   = (r_state == S_INIT_RUN) || (r_state == S_FINAL_RUN);
    w_run_b   = (r_state == S_AD_RUN) || (r_state == S_DATA_RUN);
    w_running = w_run_a || w_run_b;
    w_len     = w_run_a ? LEN_A : LEN_B;
    w_base    = w_run_a ? BASE_A : BASE_B;
    w_first   = (r_round_cnt == 4'd0);
    w_last    = (r_round_cnt == (w_len - 4'd1));
    w_ready   = (r_state == S_AD_WAIT) || (r_state == S_DATA_WAIT);
    w_xfer    = w_ready && bus.i_data_valid;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else if (!bus.i_sys_enable) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Round counter is the cycle index inside a run; it is zero in every non-run state,
  // so each run starts from zero without an explicit load.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_round_cnt   <= 4'd0;
      r_block_count <= '0;
      r_decrypt     <= 1'b0;
      r_ad_present  <= 1'b0;
      r_last_ad     <= 1'b0;
    end else if (!bus.i_sys_enable) begin
      r_round_cnt <= 4'd0;
    end else begin
      r_round_cnt <= (w_running && !w_last) ? (r_round_cnt + 4'd1) : 4'd0;
      if (r_state == S_IDLE && bus.i_start) begin
        r_decrypt     <= bus.i_decrypt;
        r_ad_present  <= bus.i_ad_present;
        r_block_count <= '0;
      end
      if (r_state == S_AD_WAIT && w_xfer) begin
        r_last_ad <= bus.i_last_block;
      end
      if (r_state == S_DATA_WAIT && w_xfer && r_block_count != CNT_MAX) begin
        r_block_count <= r_block_count + BLK_W'(1);
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (bus.i_start) w_next = S_INIT_RUN;
      S_INIT_RUN:  if (w_last) w_next = r_ad_present ? S_AD_WAIT : S_DATA_WAIT;
      S_AD_WAIT:   if (w_xfer) w_next = S_AD_RUN;
      S_AD_RUN:    if (w_last) w_next = r_last_ad ? S_DATA_WAIT : S_AD_WAIT;
      S_DATA_WAIT: if (w_xfer) w_next = bus.i_last_block ? S_FINAL_RUN : S_DATA_RUN;
      S_DATA_RUN:  if (w_last) w_next = S_DATA_WAIT;
      S_FINAL_RUN: if (w_last) w_next = S_DONE;
      S_DONE:      w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.o_ready          = w_ready;
    bus.o_busy           = (r_state != S_IDLE);
    bus.o_round          = w_running ? (w_base + r_round_cnt) : 4'd0;
    bus.o_block_count    = r_block_count;
    bus.o_mux_select     = 1'b1;
    bus.o_state_en       = w_running;
    bus.o_xor_data_begin = 1'b0;
    bus.o_xor_key_begin  = 1'b0;
    bus.o_xor_key_end    = 1'b0;
    bus.o_xor_lsb_end    = 1'b0;
    bus.o_replace_data   = 1'b0;
    bus.o_valid_out      = 1'b0;
    bus.o_tag_en         = 1'b0;
    bus.o_done           = 1'b0;
    case (r_state)
      S_INIT_RUN: begin
        bus.o_mux_select  = !w_first;
        bus.o_xor_key_end = w_last;
        bus.o_xor_lsb_end = w_last && !r_ad_present;
      end
      S_AD_RUN: begin
        bus.o_xor_data_begin = w_first;
        bus.o_xor_lsb_end    = w_last && r_last_ad;
      end
      S_DATA_RUN: begin
        bus.o_xor_data_begin = w_first;
        bus.o_valid_out      = w_first;
        bus.o_replace_data   = w_first && r_decrypt;
      end
      S_FINAL_RUN: begin
        bus.o_xor_data_begin = w_first;
        bus.o_xor_key_begin  = w_first;
        bus.o_valid_out      = w_first;
        bus.o_replace_data   = w_first && r_decrypt;
        bus.o_xor_key_end    = w_last;
        bus.o_tag_en         = w_last;
      end
      S_DONE: begin
        bus.o_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// tb/tb_ascon_ctrl_fsm.sv - randomized bench for ascon_ctrl_fsm against a transaction-flow reference
module tb_ascon_ctrl_fsm;

  localparam int M_RA = 12;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n;
  logic sys_enable, start, decrypt, ad_present, data_valid, last_block;
  logic sel;

  ascon_ctrl_fsm_if #(.BLK_W(8)) bus_a ();
  ascon_ctrl_fsm_if #(.BLK_W(2)) bus_b ();

  assign bus_a.i_sys_enable = sys_enable;
  assign bus_a.i_start      = start;
  assign bus_a.i_decrypt    = decrypt;
  assign bus_a.i_ad_present = ad_present;
  assign bus_a.i_data_valid = data_valid;
  assign bus_a.i_last_block = last_block;
  assign bus_b.i_sys_enable = sys_enable;
  assign bus_b.i_start      = start;
  assign bus_b.i_decrypt    = decrypt;
  assign bus_b.i_ad_present = ad_present;
  assign bus_b.i_data_valid = data_valid;
  assign bus_b.i_last_block = last_block;

  ascon_ctrl_fsm #(.ROUNDS_A(12), .ROUNDS_B(6), .BLK_W(8)) dut_a (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_a.slave)
  );

  ascon_ctrl_fsm #(.ROUNDS_A(12), .ROUNDS_B(8), .BLK_W(2)) dut_b (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_b.slave)
  );

  logic [23:0] obs_a, obs_b;
  assign obs_a = {bus_a.o_block_count, bus_a.o_ready, bus_a.o_busy, bus_a.o_round,
                  bus_a.o_mux_select, bus_a.o_state_en, bus_a.o_xor_data_begin,
                  bus_a.o_xor_key_begin, bus_a.o_xor_key_end, bus_a.o_xor_lsb_end,
                  bus_a.o_replace_data, bus_a.o_valid_out, bus_a.o_tag_en, bus_a.o_done};
  assign obs_b = {6'd0, bus_b.o_block_count, bus_b.o_ready, bus_b.o_busy, bus_b.o_round,
                  bus_b.o_mux_select, bus_b.o_state_en, bus_b.o_xor_data_begin,
                  bus_b.o_xor_key_begin, bus_b.o_xor_key_end, bus_b.o_xor_lsb_end,
                  bus_b.o_replace_data, bus_b.o_valid_out, bus_b.o_tag_en, bus_b.o_done};

  int    n_checks = 0;
  int    n_fail   = 0;
  int    m_cnt;
  int    m_rb;
  int    m_max;
  bit    m_abort;
  string m_phase;
  int    e_round;
  logic  e_ready, e_busy, e_mux, e_sen, e_xdb, e_xkb, e_xke, e_xle, e_repl, e_vout, e_tag, e_done;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic exp_defaults();
    e_ready = 0; e_busy = 1; e_round = 0; e_mux = 1; e_sen = 0; e_xdb = 0; e_xkb = 0;
    e_xke = 0; e_xle = 0; e_repl = 0; e_vout = 0; e_tag = 0; e_done = 0;
  endtask

  task automatic check_now();
    logic [23:0] exp;
    #1;
    exp = {8'(m_cnt), e_ready, e_busy, 4'(e_round), e_mux, e_sen, e_xdb, e_xkb,
           e_xke, e_xle, e_repl, e_vout, e_tag, e_done};
    check_eq(m_phase, {8'd0, (sel ? obs_b : obs_a)}, {8'd0, exp});
  endtask

  task automatic tick();
    if (m_abort) return;
    check_now();
    @(posedge clock);
    @(negedge clock);
    exp_defaults();
  endtask

  task automatic noise();
    start      = 1'($urandom_range(0, 1));
    data_valid = 1'($urandom_range(0, 1));
    last_block = 1'($urandom_range(0, 1));
    decrypt    = 1'($urandom_range(0, 1));
    ad_present = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    reset_n = 0; sys_enable = 1; start = 0; decrypt = 0; ad_present = 0;
    data_valid = 0; last_block = 0; m_cnt = 0; m_abort = 0;
    @(negedge clock);
    m_phase = "reset"; exp_defaults(); e_busy = 0;
    check_now();
    @(negedge clock);
    reset_n = 1;
    m_phase = "idle_after_reset"; exp_defaults(); e_busy = 0;
    tick();
  endtask

  // One whole operation as a flat program: start, init, AD blocks, data blocks, done.
  task automatic run_op(input bit dec, input int n_ad, input int n_data, input int gap,
                        input int abort_final_k, input int abort_ad_k);
    bit lastb;
    m_abort = 0;
    m_phase = "idle_start"; exp_defaults(); e_busy = 0;
    data_valid = 1'($urandom_range(0, 1)); last_block = 1'($urandom_range(0, 1));
    start = 1; decrypt = dec; ad_present = (n_ad > 0);
    tick();
    m_cnt = 0;
    m_phase = "init_run";
    for (int k = 0; k < M_RA; k++) begin
      noise();
      e_sen = 1; e_round = 12 - M_RA + k; e_mux = (k != 0);
      e_xke = (k == M_RA - 1); e_xle = (k == M_RA - 1) && (n_ad == 0);
      tick();
    end
    for (int i = 0; i < n_ad; i++) begin
      m_phase = "ad_wait";
      repeat ($urandom_range(0, gap)) begin
        noise(); data_valid = 0; e_ready = 1; tick();
      end
      noise(); data_valid = 1; last_block = (i == n_ad - 1); e_ready = 1;
      m_phase = "ad_xfer";
      tick();
      m_phase = "ad_run";
      for (int k = 0; k < m_rb; k++) begin
        noise();
        e_sen = 1; e_round = 12 - m_rb + k; e_xdb = (k == 0);
        e_xle = (k == m_rb - 1) && (i == n_ad - 1);
        if (k == abort_ad_k && !m_abort) begin
          check_now();
          reset_n = 0;
          exp_defaults(); e_busy = 0; m_cnt = 0; m_phase = "reset_abort";
          check_now();
          @(posedge clock);
          @(negedge clock);
          reset_n = 1;
          m_abort = 1;
        end else begin
          tick();
        end
      end
    end
    for (int j = 0; j < n_data; j++) begin
      lastb = (j == n_data - 1);
      m_phase = "data_wait";
      repeat ($urandom_range(0, gap)) begin
        noise(); data_valid = 0; e_ready = 1; tick();
      end
      noise(); data_valid = 1; last_block = lastb; e_ready = 1;
      m_phase = "data_xfer";
      tick();
      if (!m_abort) m_cnt = (m_cnt < m_max) ? m_cnt + 1 : m_cnt;
      if (!lastb) begin
        m_phase = "data_run";
        for (int k = 0; k < m_rb; k++) begin
          noise();
          e_sen = 1; e_round = 12 - m_rb + k;
          e_xdb = (k == 0); e_vout = (k == 0); e_repl = (k == 0) && dec;
          tick();
        end
      end else begin
        m_phase = "final_run";
        for (int k = 0; k < M_RA; k++) begin
          noise();
          e_sen = 1; e_round = 12 - M_RA + k;
          e_xdb = (k == 0); e_xkb = (k == 0); e_vout = (k == 0); e_repl = (k == 0) && dec;
          e_xke = (k == M_RA - 1); e_tag = (k == M_RA - 1);
          if (k == abort_final_k && !m_abort) begin
            sys_enable = 0;
            m_phase = "final_abort";
            tick();
            sys_enable = 1;
            m_abort = 1;
          end else begin
            tick();
          end
        end
      end
    end
    m_phase = "done";
    noise(); e_done = 1;
    tick();
    m_abort = 0;
    m_phase = "idle_after_op"; exp_defaults(); e_busy = 0;
    noise(); start = 0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no end expected end");
    $fatal(1);
  end

  initial begin
    sel = 0; m_rb = 6; m_max = 255;
    do_reset();
    run_op(0, 0, 1, 3, -1, -1);
    run_op(0, 2, 3, 3, -1, -1);
    repeat (6) run_op(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(1, 4), 3, -1, -1);
    run_op(0, 1, 2, 2, 3, -1);
    run_op(1, 0, 2, 2, -1, -1);
    run_op(0, 2, 2, 2, -1, 2);
    run_op(1, 1, 1, 2, -1, -1);
    run_op(0, 0, 260, 1, -1, -1);

    sel = 1; m_rb = 8; m_max = 3;
    do_reset();
    run_op(1, 1, 3, 3, -1, -1);
    run_op(0, 0, 5, 2, -1, -1);
    repeat (4) run_op(1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(1, 6), 3, -1, -1);
    run_op(1, 2, 2, 2, 3, -1);
    run_op(0, 1, 1, 1, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
